// File: rtl/async_fifo_pkg.sv
// Shared types and defaults for the async FIFO read-side logic.
// Latency: n/a (types, constants and a constant helper only).
// Backpressure: n/a.
package async_fifo_pkg;

  // Defaults shared with the FIFO instance this controller drains.
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_BURST_LEN  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } drain_state_t;

  // Used to size the shared latency/gap down-counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer between the FIFO capture point and the consumer.
// Latency: a push is visible on out_valid/out_data the cycle after the push edge.
// Backpressure: out_ready low holds the head; free drops when both entries are full.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes both entries)
//   in_data, in_valid push side; in_valid is a one-cycle push strobe
//   out_data, out_valid, out_ready  downstream stream, pop on out_valid && out_ready
//   free              at least one entry empty this cycle (ignores a same-cycle pop)
module stream_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  free
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            count;
  logic                  pop;
  logic                  push;

  assign pop  = out_valid && out_ready;
  // The controller never pushes into a full buffer without a pop; the guard
  // only keeps the occupancy counter from wrapping if that were violated.
  assign push = in_valid && ((count != 2'd2) || pop);

  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign free      = (count != 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head <= in_data;
          end else begin
            tail <= in_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the incoming word lands behind whatever
          // remains after the pop.
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains BURST_LEN words from the async FIFO read port per start and streams them out.
// Latency: R_EN one cycle after ISSUE sees data; capture READ_LAT edges later; out_valid one cycle after capture.
// Backpressure: reads are only issued while the skid buffer has a free slot, so out_ready low stalls in ISSUE.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin a burst (only honoured in IDLE)
//   fifo_empty, fifo_data  FIFO EMPTY flag and DATA_OUT
//   r_en                   registered FIFO read strobe, single-cycle pulses
//   out_data, out_valid, out_ready  downstream valid/ready stream
//   rd_count               words captured in the current burst (held after DONE)
//   busy                   controller not in IDLE
//   burst_done             one-cycle pulse while in DONE
module fifo_drain_ctrl
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int BURST_LEN   = DEFAULT_BURST_LEN,
  parameter int READ_LAT    = 1,
  parameter int IDLE_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_data,
  output logic                           r_en,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(BURST_LEN+1)-1:0] rd_count,
  output logic                           busy,
  output logic                           burst_done
);

  localparam int RCW = $clog2(BURST_LEN + 1);
  localparam int CW  = $clog2(max_int(READ_LAT, IDLE_CYCLES) + 1);

  // Both WAIT and GAP count down to zero, so the loads are one less than
  // the number of cycles spent in the state.
  localparam logic [CW-1:0]  LAT_LOAD   = CW'(READ_LAT - 1);
  localparam logic [CW-1:0]  GAP_LOAD   = CW'((IDLE_CYCLES > 0) ? (IDLE_CYCLES - 1) : 0);
  localparam logic [RCW-1:0] BURST_LAST = RCW'(BURST_LEN);

  drain_state_t   state;
  drain_state_t   state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [RCW-1:0] rd_cnt_nxt;
  logic [RCW-1:0] rd_inc;
  logic           r_en_nxt;
  logic           push;
  logic           skid_free;
  logic           slot_ok;

  assign rd_inc = rd_count + 1'b1;

  // A pop on this edge frees a slot even when the buffer currently holds two.
  // Only one read is ever outstanding, so a slot seen free here is still free
  // when that read is captured.
  assign slot_ok = skid_free || (out_valid && out_ready);

  assign busy       = (state != IDLE);
  assign burst_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_count <= '0;
      r_en     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rd_count <= rd_cnt_nxt;
      r_en     <= r_en_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rd_cnt_nxt = rd_count;
    r_en_nxt   = 1'b0;
    push       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = ISSUE;
          rd_cnt_nxt = '0;
        end
      end

      ISSUE: begin
        if (!fifo_empty && slot_ok) begin
          state_nxt = WAIT;
          r_en_nxt  = 1'b1;
          cnt_nxt   = LAT_LOAD;
        end
      end

      WAIT: begin
        // FIFO_EMPTY is deliberately ignored here: the issued read completes.
        if (cnt == '0) begin
          push       = 1'b1;
          rd_cnt_nxt = rd_inc;
          if (rd_inc == BURST_LAST) begin
            state_nxt = DONE;
          end else if (IDLE_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            state_nxt = ISSUE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_nxt = ISSUE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      DONE: begin
        // start is not looked at here; IDLE has to be re-entered first.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (fifo_data),
    .in_valid (push),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .free     (skid_free)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: two instances (READ_LAT=1/IDLE_CYCLES=0 and
// READ_LAT=2/IDLE_CYCLES=3) share stimulus and are each checked every cycle
// against a queue-based model of the FIFO, the in-flight read and the stream.
module tb_fifo_drain_ctrl;

  localparam int BL = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    start;
  logic [1:0]    fifo_empty;
  logic [DW-1:0] fifo_data [2];
  logic          out_ready;
  logic [1:0]    r_en;
  logic [1:0]    out_valid;
  logic [1:0]    busy;
  logic [1:0]    burst_done;
  logic [DW-1:0] out_data [2];
  logic [2:0]    rd_count [2];

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL), .READ_LAT(1), .IDLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .r_en(r_en[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .rd_count(rd_count[0]),
    .busy(busy[0]), .burst_done(burst_done[0])
  );

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .BURST_LEN(BL), .READ_LAT(2), .IDLE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .r_en(r_en[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .rd_count(rd_count[1]),
    .busy(busy[1]), .burst_done(burst_done[1])
  );

  // Reference model state
  logic [DW-1:0] fq [2][$];   // FIFO contents
  logic [DW-1:0] eq [2][$];   // words captured, not yet accepted downstream
  logic [DW-1:0] inflight [2];
  int  cap_due [2];
  int  last_ren [2];
  int  ren_cnt [2];
  int  rx_cnt [2];
  int  done_cnt [2];
  int  exp_rd [2];
  bit  busy_m [2];
  bit  prev_done [2];
  bit  hold_empty;
  bit  exact_gap;
  int  cyc;
  int  n_assert;
  int  n_fail;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int min_sp(input int k);
    return lat(k) + ((k == 0) ? 0 : 3) + 1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h (cycle %0d)", tag, k, obs, req, cyc);
    end
  endtask

  task automatic update_empty();
    for (int k = 0; k < 2; k++) fifo_empty[k] = hold_empty || (fq[k].size() == 0);
  endtask

  task automatic clear_fifo();
    for (int k = 0; k < 2; k++) fq[k].delete();
  endtask

  task automatic load_rand(input int n);
    logic [DW-1:0] w;
    clear_fifo();
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom);
      fq[0].push_back(w);
      fq[1].push_back(w);
    end
    update_empty();
  endtask

  // One clock: account for what happens at the coming edge, then sample at
  // the following falling edge and update/check the model.
  task automatic tick();
    bit was_rst;
    bit cap_this;
    bit done_e;
    logic [DW-1:0] w;
    was_rst = rst;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        if (out_valid[k] && out_ready && eq[k].size() != 0) begin
          w = eq[k].pop_front();
          chk("out_data", k, 32'(out_data[k]), 32'(w));
          rx_cnt[k]++;
        end
        if (start[k] && !busy_m[k]) begin
          busy_m[k]   = 1'b1;
          exp_rd[k]   = 0;
          ren_cnt[k]  = 0;
          rx_cnt[k]   = 0;
          done_cnt[k] = 0;
          last_ren[k] = -1000;
        end
      end
    end
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      cap_this = 1'b0;
      if (was_rst) begin
        eq[k].delete();
        exp_rd[k]    = 0;
        busy_m[k]    = 1'b0;
        cap_due[k]   = -1;
        prev_done[k] = 1'b0;
        last_ren[k]  = -1000;
        chk("ren_after_rst", k, 32'(r_en[k]), 0);
      end else if (cyc == cap_due[k]) begin
        cap_this = 1'b1;
        exp_rd[k]++;
        eq[k].push_back(inflight[k]);
        cap_due[k] = -1;
      end
      if (prev_done[k]) busy_m[k] = 1'b0;
      done_e = cap_this && (exp_rd[k] == BL);
      if (r_en[k]) begin
        chk("ren_spacing_ok", k, 32'((cyc - last_ren[k]) >= min_sp(k)), 1);
        if (exact_gap && last_ren[k] >= 0) chk("ren_exact_gap", k, 32'(cyc - last_ren[k]), 32'(min_sp(k)));
        chk("ren_when_empty", k, 32'(fifo_empty[k]), 0);
        if (fq[k].size() != 0) inflight[k] = fq[k].pop_front();
        else inflight[k] = '0;
        fifo_data[k] = inflight[k];
        cap_due[k]   = cyc + lat(k);
        ren_cnt[k]++;
        last_ren[k]  = cyc;
      end
      if (burst_done[k]) done_cnt[k]++;
      chk("rd_count", k, 32'(rd_count[k]), 32'(exp_rd[k]));
      chk("busy", k, 32'(busy[k]), 32'(busy_m[k]));
      chk("burst_done", k, 32'(burst_done[k]), 32'(done_e));
      chk("out_valid", k, 32'(out_valid[k]), 32'(eq[k].size() != 0));
      prev_done[k] = done_e;
    end
    update_empty();
  endtask

  task automatic wait_idle(input int bound, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rnd) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        hold_empty = ($urandom_range(0, 5) == 0);
        update_empty();
      end
      tick();
      if (busy == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 0, 32'(ok), 1);
    hold_empty = 1'b0;
    update_empty();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pulse_start();
    start = 2'b11;
    tick();
    start = 2'b00;
  endtask

  initial begin
    bit ok;
    n_assert = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    start = 2'b00;
    out_ready = 1'b0;
    hold_empty = 1'b0;
    exact_gap = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fifo_data[k] = '0;
      inflight[k] = '0;
      cap_due[k] = -1;
      last_ren[k] = -1000;
      ren_cnt[k] = 0;
      rx_cnt[k] = 0;
      done_cnt[k] = 0;
      exp_rd[k] = 0;
      busy_m[k] = 1'b0;
      prev_done[k] = 1'b0;
    end
    clear_fifo();
    update_empty();

    // Reset state
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_r_en", k, 32'(r_en[k]), 0);
      chk("rst_out_valid", k, 32'(out_valid[k]), 0);
      chk("rst_out_data", k, 32'(out_data[k]), 0);
      chk("rst_rd_count", k, 32'(rd_count[k]), 0);
      chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_burst_done", k, 32'(burst_done[k]), 0);
    end
    rst = 1'b0;
    tick();

    // Basic burst A1..A4, free-flowing: exact R_EN spacing
    clear_fifo();
    for (int i = 0; i < BL; i++) begin
      fq[0].push_back(8'hA1 + 8'(i));
      fq[1].push_back(8'hA1 + 8'(i));
    end
    update_empty();
    out_ready = 1'b1;
    exact_gap = 1'b1;
    pulse_start();
    wait_idle(200, 1'b0);
    drain();
    exact_gap = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("basic_ren_cnt", k, 32'(ren_cnt[k]), BL);
      chk("basic_rx_cnt", k, 32'(rx_cnt[k]), BL);
      chk("basic_done_cnt", k, 32'(done_cnt[k]), 1);
      chk("basic_rd_count", k, 32'(rd_count[k]), BL);
    end

    // EMPTY held high for 10 cycles after start
    load_rand(BL);
    hold_empty = 1'b1;
    update_empty();
    pulse_start();
    repeat (10) begin
      tick();
      for (int k = 0; k < 2; k++) chk("empty_hold_ren", k, 32'(r_en[k]), 0);
    end
    hold_empty = 1'b0;
    update_empty();
    tick();
    for (int k = 0; k < 2; k++) chk("first_ren_after_empty", k, 32'(r_en[k]), 1);
    wait_idle(200, 1'b0);
    drain();
    for (int k = 0; k < 2; k++) begin
      chk("empty_rd_count", k, 32'(rd_count[k]), BL);
      chk("empty_rx_cnt", k, 32'(rx_cnt[k]), BL);
    end

    // OUT_READY low for 20 cycles: two words buffered, then stall
    load_rand(BL);
    out_ready = 1'b0;
    pulse_start();
    repeat (20) tick();
    for (int k = 0; k < 2; k++) begin
      chk("stall_ren_cnt", k, 32'(ren_cnt[k]), 2);
      chk("stall_rd_count", k, 32'(rd_count[k]), 2);
      chk("stall_out_valid", k, 32'(out_valid[k]), 1);
      chk("stall_busy", k, 32'(busy[k]), 1);
    end
    out_ready = 1'b1;
    wait_idle(200, 1'b0);
    drain();
    for (int k = 0; k < 2; k++) chk("stall_rx_cnt", k, 32'(rx_cnt[k]), BL);

    // Reset while instance 1 is in WAIT (second read outstanding)
    load_rand(BL);
    out_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ren_cnt[1] == 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_wait_reached", 1, 32'(ok), 1);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("midrst_r_en", k, 32'(r_en[k]), 0);
      chk("midrst_out_valid", k, 32'(out_valid[k]), 0);
      chk("midrst_rd_count", k, 32'(rd_count[k]), 0);
      chk("midrst_busy", k, 32'(busy[k]), 0);
    end
    rst = 1'b0;
    tick();
    load_rand(BL);
    out_ready = 1'b1;
    pulse_start();
    wait_idle(200, 1'b0);
    drain();
    for (int k = 0; k < 2; k++) begin
      chk("postrst_rd_count", k, 32'(rd_count[k]), BL);
      chk("postrst_rx_cnt", k, 32'(rx_cnt[k]), BL);
    end

    // START while busy and in the DONE cycle: ignored
    load_rand(2 * BL);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      start = (i < 5) ? 2'b11 : burst_done;
      tick();
      if (i > 0 && busy == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    start = 2'b00;
    chk("busy_start_timeout", 0, 32'(ok), 1);
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      chk("busy_start_rd_count", k, 32'(rd_count[k]), BL);
      chk("busy_start_ren_cnt", k, 32'(ren_cnt[k]), BL);
      chk("busy_start_fifo_left", k, 32'(fq[k].size()), BL);
    end

    // Randomised backpressure and EMPTY toggling
    for (int b = 0; b < 5; b++) begin
      load_rand(BL + int'($urandom_range(0, 2)));
      pulse_start();
      wait_idle(800, 1'b1);
      drain();
      for (int k = 0; k < 2; k++) begin
        chk("rand_rd_count", k, 32'(rd_count[k]), BL);
        chk("rand_rx_cnt", k, 32'(rx_cnt[k]), BL);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
